// File: rtl/mem_pkg.sv
// mem_pkg: shared types and constants for the data-memory responder.
//   state_t    - responder FSM states (IDLE, WAIT, RESP)
//   WORD_W     - data word width in bits
//   BURST_LEN  - beats in a line read (used when MEM_RESP_BURST_EN is defined)
//   LAT_CNT_W  - width of the latency down-counter (LATENCY legal 1..15)
package mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int WORD_W    = 16;
    localparam int BURST_LEN = 4;
    localparam int LAT_CNT_W = 4;

endpackage

// File: rtl/data_mem_responder_mem_array.sv
// mem_array: 2**MEM_AW x WORD_W storage, synchronous write, combinational read.
// Contents are never reset.
//   clk    in  - system clock, rising edge
//   we     in  - write enable, write happens at the rising edge
//   waddr  in  - write word index
//   wdata  in  - write data
//   raddr  in  - read word index
//   rdata  out - read data for raddr (combinational)
module mem_array
    import mem_pkg::*;
#(
    parameter int MEM_AW = 10
) (
    input  logic              clk,
    input  logic              we,
    input  logic [MEM_AW-1:0] waddr,
    input  logic [WORD_W-1:0] wdata,
    input  logic [MEM_AW-1:0] raddr,
    output logic [WORD_W-1:0] rdata
);

    logic [WORD_W-1:0] mem [2**MEM_AW];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/data_mem_responder.sv
// data_mem_responder: multi-cycle data-memory target on a valid/ready request
// port. One request at a time; the response appears LATENCY cycles after the
// accept and is never backpressured.
// Optional feature macro: MEM_RESP_BURST_EN (4-beat line reads on req_burst).
//   clk         in  - system clock, rising edge
//   rst         in  - asynchronous, active-high reset
//   req_valid   in  - request present
//   req_ready   out - high only in IDLE
//   req_wr      in  - 1 = write, 0 = read
//   req_burst   in  - 4-word line read (ignored without MEM_RESP_BURST_EN)
//   req_addr    in  - byte address; word index = req_addr[MEM_AW:1]
//   req_wdata   in  - write data
//   resp_valid  out - response beat valid (one cycle per beat)
//   resp_last   out - final beat of the response
//   resp_rdata  out - read data; 0 on write ack; holds when not valid
module data_mem_responder
    import mem_pkg::*;
#(
    parameter int LATENCY = 4,
    parameter int MEM_AW  = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_wr,
    input  logic              req_burst,
    input  logic [15:0]       req_addr,
    input  logic [WORD_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic              resp_last,
    output logic [WORD_W-1:0] resp_rdata
);

    state_t                 state_q, state_d;
    logic [LAT_CNT_W-1:0]   cnt_q, cnt_d;
    logic                   resp_valid_q, resp_valid_d;
    logic                   resp_last_q, resp_last_d;
    logic [WORD_W-1:0]      resp_rdata_q, resp_rdata_d;
    logic                   wr_q, wr_d;
    logic [MEM_AW-1:0]      idx_q, idx_d;
    logic [WORD_W-1:0]      wdata_q, wdata_d;

    logic [MEM_AW-1:0]      rd_idx;
    logic [WORD_W-1:0]      rd_data;
    logic                   mem_we;

`ifdef MEM_RESP_BURST_EN
    logic                   burst_q, burst_d;
    logic [1:0]             beat_q, beat_d;
`endif

    // Byte-offset bit and bits above the word index are don't-care: addresses
    // alias modulo 2**(MEM_AW+1) bytes.
    logic unused_req;
`ifdef MEM_RESP_BURST_EN
    assign unused_req = ^{req_addr[0], req_addr[15:MEM_AW+1]};
`else
    assign unused_req = ^{req_addr[0], req_addr[15:MEM_AW+1], req_burst};
`endif

    mem_array #(
        .MEM_AW (MEM_AW)
    ) u_mem_array (
        .clk   (clk),
        .we    (mem_we),
        .waddr (idx_q),
        .wdata (wdata_q),
        .raddr (rd_idx),
        .rdata (rd_data)
    );

    assign req_ready  = (state_q == IDLE);
    assign resp_valid = resp_valid_q;
    assign resp_last  = resp_last_q;
    assign resp_rdata = resp_rdata_q;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        resp_valid_d = 1'b0;
        resp_last_d  = 1'b0;
        resp_rdata_d = resp_rdata_q;
        wr_d         = wr_q;
        idx_d        = idx_q;
        wdata_d      = wdata_q;
        rd_idx       = idx_q;
        mem_we       = 1'b0;
`ifdef MEM_RESP_BURST_EN
        burst_d      = burst_q;
        beat_d       = beat_q;
`endif

        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    state_d = WAIT;
                    cnt_d   = LAT_CNT_W'(LATENCY - 1);
                    wr_d    = req_wr;
                    idx_d   = req_addr[MEM_AW:1];
                    wdata_d = req_wdata;
`ifdef MEM_RESP_BURST_EN
                    // A burst write degenerates to a single write.
                    burst_d = req_burst & ~req_wr;
`endif
                end
            end

            WAIT: begin
                if (cnt_q == '0) begin
                    state_d      = RESP;
                    resp_valid_d = 1'b1;
                    if (wr_q) begin
                        resp_rdata_d = '0;
                        resp_last_d  = 1'b1;
                    end else begin
`ifdef MEM_RESP_BURST_EN
                        beat_d = 2'd0;
                        // Line reads always start at word 0 of the line.
                        if (burst_q) begin
                            rd_idx = {idx_q[MEM_AW-1:2], 2'd0};
                        end
                        resp_last_d = ~burst_q;
`else
                        resp_last_d = 1'b1;
`endif
                        resp_rdata_d = rd_data;
                    end
                end else begin
                    cnt_d = cnt_q - LAT_CNT_W'(1);
                end
            end

            RESP: begin
`ifdef MEM_RESP_BURST_EN
                if (burst_q && (beat_q != 2'(BURST_LEN - 1))) begin
                    beat_d       = beat_q + 2'd1;
                    rd_idx       = {idx_q[MEM_AW-1:2], beat_d};
                    resp_valid_d = 1'b1;
                    resp_last_d  = (beat_d == 2'(BURST_LEN - 1));
                    resp_rdata_d = rd_data;
                end else
`endif
                begin
                    state_d = IDLE;
                    // The write lands at the edge that ends the ack beat, so a
                    // reset before that edge leaves the array untouched.
                    mem_we  = wr_q;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            resp_valid_q <= 1'b0;
            resp_last_q  <= 1'b0;
            resp_rdata_q <= '0;
            wr_q         <= 1'b0;
`ifdef MEM_RESP_BURST_EN
            burst_q      <= 1'b0;
            beat_q       <= 2'd0;
`endif
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            resp_valid_q <= resp_valid_d;
            resp_last_q  <= resp_last_d;
            resp_rdata_q <= resp_rdata_d;
            wr_q         <= wr_d;
`ifdef MEM_RESP_BURST_EN
            burst_q      <= burst_d;
            beat_q       <= beat_d;
`endif
        end
    end

    // Request address and write data are pure datapath; no reset needed.
    always_ff @(posedge clk) begin
        idx_q   <= idx_d;
        wdata_q <= wdata_d;
    end

endmodule

// File: tb/tb_data_mem_responder.sv
module tb_data_mem_responder;

    localparam int LAT    = 4;
    localparam int AW     = 10;
`ifdef MEM_RESP_BURST_EN
    localparam bit BURST  = 1'b1;
`else
    localparam bit BURST  = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_wr;
    logic        req_burst;
    logic [15:0] req_addr;
    logic [15:0] req_wdata;
    logic        resp_valid;
    logic        resp_last;
    logic [15:0] resp_rdata;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference memory, indexed by word.
    logic [15:0] model [2**AW];

    data_mem_responder #(
        .LATENCY (LAT),
        .MEM_AW  (AW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_wr     (req_wr),
        .req_burst  (req_burst),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_last  (resp_last),
        .resp_rdata (resp_rdata)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog");
    end

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] mk_addr(input int w);
        logic [15:0] a;
        a = 16'($urandom) & 16'hF800;
        a = a | 16'(w << 1) | 16'($urandom_range(0, 1));
        return a;
    endfunction

    // Issue one request at a negedge with req_ready expected high, then check
    // every cycle until the responder is ready again. Response beats are due in
    // cycles LAT..LAT+nb-1 counted from the first cycle after the accept edge.
    task automatic do_req(input bit wr, input bit burst, input bit hold,
                          input logic [15:0] addr, input logic [15:0] wdata);
        int w;
        int nb;
        int line;
        bit exp_v;
        logic [15:0] exp_d;
        logic [15:0] last_d;
        w      = int'(addr[AW:1]);
        nb     = (BURST && burst && !wr) ? 4 : 1;
        line   = w & ~3;
        last_d = 16'h0;
        req_valid = 1'b1;
        req_wr    = wr;
        req_burst = burst;
        req_addr  = addr;
        req_wdata = wdata;
        chk_eq("ready_before_accept", req_ready, 1);
        @(posedge clk);
        for (int off = 0; off <= LAT + nb; off++) begin
            @(negedge clk);
            if (off == 0) begin
                if (hold) begin
                    req_wr    = $urandom_range(0, 1);
                    req_burst = $urandom_range(0, 1);
                    req_addr  = 16'($urandom);
                    req_wdata = 16'($urandom);
                end else begin
                    req_valid = 1'b0;
                end
            end
            exp_v = (off >= LAT) && (off < LAT + nb);
            chk_eq("resp_valid", resp_valid, exp_v);
            chk_eq("resp_last", resp_last, (off == LAT + nb - 1));
            chk_eq("req_ready", req_ready, (off >= LAT + nb));
            if (exp_v) begin
                if (wr) exp_d = 16'h0;
                else if (nb == 4) exp_d = model[line + off - LAT];
                else exp_d = model[w];
                chk_eq(wr ? "ack_rdata" : "rd_rdata", resp_rdata, exp_d);
                last_d = exp_d;
            end
            if (off == LAT + nb) begin
                chk_eq("rdata_hold", resp_rdata, last_d);
            end
        end
        req_valid = 1'b0;
        if (wr) model[w] = wdata;
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = 1'b0;
        req_wr    = 1'b0;
        req_burst = 1'b0;
        req_addr  = 16'h0;
        req_wdata = 16'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_eq("rst_ready", req_ready, 1);
        chk_eq("rst_valid", resp_valid, 0);
        chk_eq("rst_last", resp_last, 0);
        chk_eq("rst_rdata", resp_rdata, 0);
        rst = 1'b0;
        @(negedge clk);

        // Fill the working region so every later read has a known value.
        for (int w = 0; w < 64; w++) begin
            do_req(1'b1, 1'b0, 1'b0, mk_addr(w), 16'($urandom));
        end

        // Write then read back, byte-offset ignored, upper bits alias.
        do_req(1'b1, 1'b0, 1'b0, 16'h0010, 16'hBEEF);
        do_req(1'b0, 1'b0, 1'b0, 16'h0010, 16'h0000);
        do_req(1'b0, 1'b0, 1'b0, 16'h0011, 16'h0000);
        do_req(1'b0, 1'b0, 1'b0, 16'h0810, 16'h0000);
        chk_eq("model_beef", model[8], 16'hBEEF);

        // Request held high through a whole read.
        do_req(1'b0, 1'b0, 1'b1, 16'h0020, 16'h0000);
        do_req(1'b0, 1'b0, 1'b0, 16'h0022, 16'h0000);

        // Reset during the WAIT of a write: array keeps the old word.
        req_valid = 1'b1;
        req_wr    = 1'b1;
        req_burst = 1'b0;
        req_addr  = 16'h000A;
        req_wdata = ~model[5];
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        #1 rst = 1'b1;
        #1;
        chk_eq("midrst_ready", req_ready, 1);
        chk_eq("midrst_valid", resp_valid, 0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < LAT + 3; i++) begin
            @(negedge clk);
            chk_eq("midrst_no_resp", resp_valid, 0);
            chk_eq("midrst_ready_idle", req_ready, 1);
        end
        do_req(1'b0, 1'b0, 1'b0, 16'h000A, 16'h0000);

`ifdef MEM_RESP_BURST_EN
        // Line read starting mid-line still returns words 8..11 in order.
        for (int w = 8; w < 12; w++) begin
            do_req(1'b1, 1'b0, 1'b0, 16'(w << 1), 16'(w - 7));
        end
        do_req(1'b0, 1'b1, 1'b0, 16'h0014, 16'h0000);
        do_req(1'b1, 1'b1, 1'b0, 16'h0016, 16'h5A5A);
        do_req(1'b0, 1'b0, 1'b0, 16'h0016, 16'h0000);
`endif

        // Randomized mix of reads, writes, bursts and held requests.
        for (int i = 0; i < 150; i++) begin
            do_req($urandom_range(0, 2) == 0, $urandom_range(0, 1), $urandom_range(0, 3) == 0,
                   mk_addr($urandom_range(0, 63)), 16'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
